// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b - borrow_in one bit per clock,
// streaming each difference bit out and publishing the parallel result at the end.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, diff_nx;
  logic [CW-1:0]    cnt;
  logic             br, d, br_nx, last;

  // Per-bit full subtractor and next-state decode
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_nx    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last     = (cnt == CW'(WIDTH - 1));
    diff_nx  = diff;
    diff_nx[cnt] = d;
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand shifters, borrow flop and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa         <= '0;
      sb         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done      <= 1'b0;
      bit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa         <= a;
            sb         <= b;
            br         <= borrow_in;
            cnt        <= '0;
            busy       <= 1'b1;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
          end
        end
        RUN: begin
          bit_out   <= d;
          bit_valid <= 1'b1;
          diff      <= diff_nx;
          br        <= br_nx;
          sa        <= sa >> 1;
          sb        <= sb >> 1;
          cnt       <= cnt + CW'(1);
          if (last) begin
            done       <= 1'b1;
            borrow_out <= br_nx;
            zero       <= (diff_nx == '0);
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=3 against an
// arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, bit8, bv8, done8, bo8, z8;
  logic [7:0] diff8;

  logic       start3 = 1'b0, bin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, bit3, bv3, done3, bo3, z3;
  logic [2:0] diff3;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .bit_out(bit8), .bit_valid(bv8), .done(done8),
    .diff(diff8), .borrow_out(bo8), .zero(z8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .CLK(clk), .RST(rst), .start(start3), .a(a3), .b(b3), .borrow_in(bin3),
    .busy(busy3), .bit_out(bit3), .bit_valid(bv3), .done(done3),
    .diff(diff3), .borrow_out(bo3), .zero(z3)
  );

  int checks = 0;
  int errors = 0;

  // Observed values of the currently selected instance
  logic o_busy, o_bit, o_bv, o_done, o_bo, o_z;
  int   o_diff;

  task automatic sample(input int w);
    if (w == 8) begin
      o_busy = busy8; o_bit = bit8; o_bv = bv8; o_done = done8;
      o_bo = bo8; o_z = z8; o_diff = int'(diff8);
    end else begin
      o_busy = busy3; o_bit = bit3; o_bv = bv3; o_done = done3;
      o_bo = bo3; o_z = z3; o_diff = int'(diff3);
    end
  endtask

  task automatic drive(input int w, input logic s, input int ia, input int ib, input int ibin);
    if (w == 8) begin
      start8 = s; a8 = 8'(ia); b8 = 8'(ib); bin8 = 1'(ibin);
    end else begin
      start3 = s; a3 = 3'(ia); b3 = 3'(ib); bin3 = 1'(ibin);
    end
  endtask

  function automatic void ref_sub(input int w, input int ia, input int ib, input int ibin,
                                  output int ed, output int eb, output int ez);
    int mask;
    mask = (1 << w) - 1;
    ed = (ia - ib - ibin) & mask;
    eb = (ia < ib + ibin) ? 1 : 0;
    ez = (ed == 0) ? 1 : 0;
  endfunction

  // One operation from an idle DUT; collects stream, latency and final results
  int r_bits, r_nvalid, r_lat, r_ndone, r_coinc, r_diff, r_bo, r_z;

  task automatic do_op(input int w, input int ia, input int ib, input int ibin);
    r_bits = 0; r_nvalid = 0; r_lat = -1; r_ndone = 0; r_coinc = 1;
    @(negedge clk);
    drive(w, 1'b1, ia, ib, ibin);
    @(negedge clk);
    drive(w, 1'b0, 0, 0, 0);
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge clk);
      sample(w);
      if (o_bv) begin
        if (r_nvalid < w) r_bits |= (int'(o_bit) << r_nvalid);
        r_nvalid++;
      end
      if (o_done) begin
        r_ndone++;
        r_lat = c;
        if (!o_bv) r_coinc = 0;
      end
    end
    r_diff = o_diff; r_bo = int'(o_bo); r_z = int'(o_z);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy8, bit8, bv8, done8, bo8, z8} !== 6'b0 || diff8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b diff=%h required flags=000000 diff=00",
               {busy8, bit8, bv8, done8, bo8, z8}, diff8);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, bv8, done8, diff8} !== 11'b0 || {busy3, bv3, done3, diff3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy8=%b bv8=%b done8=%b diff8=%h busy3=%b required all 0",
               busy8, bv8, done8, diff8, busy3);
    end
  endtask

  task automatic test_basic();
    do_op(8, 8'h05, 8'h03, 0);
    checks++;
    if (r_bits !== 32'h02 || r_nvalid !== 8) begin
      errors++;
      $display("FAIL basic_stream: bits=%h count=%0d required bits=02 count=8", r_bits, r_nvalid);
    end
    checks++;
    if (r_lat !== 8 || r_ndone !== 1 || r_coinc !== 1) begin
      errors++;
      $display("FAIL basic_done_timing: lat=%0d dones=%0d coincide=%0d required 8 1 1",
               r_lat, r_ndone, r_coinc);
    end
    checks++;
    if (r_diff !== 32'h02 || r_bo !== 0 || r_z !== 0) begin
      errors++;
      $display("FAIL basic_result: diff=%h bo=%0d z=%0d required 02 0 0", r_diff, r_bo, r_z);
    end
  endtask

  task automatic test_borrow_cases();
    int va[4] = '{8'h03, 8'h00, 8'h80, 8'h00};
    int vb[4] = '{8'h05, 8'hFF, 8'h7F, 8'h00};
    int vi[4] = '{0, 0, 1, 1};
    int xd[4] = '{8'hFE, 8'h01, 8'h00, 8'hFF};
    int xb[4] = '{1, 1, 0, 1};
    int xz[4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      do_op(8, va[i], vb[i], vi[i]);
      checks++;
      if (r_diff !== xd[i] || r_bo !== xb[i] || r_z !== xz[i] || r_bits !== xd[i]) begin
        errors++;
        $display("FAIL borrow_case%0d: diff=%h bo=%0d z=%0d bits=%h required %h %0d %0d %h",
                 i, r_diff, r_bo, r_z, r_bits, xd[i], xb[i], xz[i], xd[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int qa[$], qb[$], qi[$];
    int last_acc, accepts, dones, ed, eb, ez, ea, eb_op, ei;
    last_acc = -1; accepts = 0; dones = 0;
    @(negedge clk);
    start8 = 1'b1;
    for (int cyc = 0; cyc < 60 + 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done8) begin
        dones++;
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done: done at cycle %0d with no pending op required none", cyc);
        end else begin
          ea = qa.pop_front(); eb_op = qb.pop_front(); ei = qi.pop_front();
          ref_sub(8, ea, eb_op, ei, ed, eb, ez);
          if (int'(diff8) !== ed || int'(bo8) !== eb || int'(z8) !== ez) begin
            errors++;
            $display("FAIL b2b_result: diff=%h bo=%b z=%b required %h %0d %0d",
                     diff8, bo8, z8, ed, eb, ez);
          end
        end
      end
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      if (cyc >= 59) start8 = 1'b0;
      else if (!busy8) begin
        qa.push_back(int'(a8)); qb.push_back(int'(b8)); qi.push_back(int'(bin8));
        accepts++;
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 10) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles between accepts required 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
    end
    checks++;
    if (dones !== accepts || qa.size() !== 0 || accepts < 5) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d accepts=%0d pending=%0d required equal, none pending",
               dones, accepts, qa.size());
    end
  endtask

  task automatic test_async_reset();
    int seen, dones;
    seen = 0; dones = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 0; c < 20 && seen < 5; c++) begin
      @(negedge clk);
      if (bv8) seen++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, bit8, bv8, done8, bo8, z8} !== 6'b0 || diff8 !== 8'h00 || seen !== 5) begin
      errors++;
      $display("FAIL async_reset_outputs: flags=%b diff=%h bits_seen=%0d required 000000 00 5",
               {busy8, bit8, bv8, done8, bo8, z8}, diff8, seen);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b0;
      if (done8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL async_reset_no_done: dones=%0d required 0", dones);
    end
    do_op(8, 8'h10, 8'h01, 0);
    checks++;
    if (r_diff !== 32'h0F || r_bo !== 0 || r_z !== 0) begin
      errors++;
      $display("FAIL async_reset_recover: diff=%h bo=%0d z=%0d required 0f 0 0", r_diff, r_bo, r_z);
    end
  endtask

  task automatic test_random(input int w, input int n);
    int ia, ib, ii, ed, eb, ez, bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      ia = int'($urandom_range((1 << w) - 1, 0));
      ib = int'($urandom_range((1 << w) - 1, 0));
      ii = int'($urandom_range(1, 0));
      do_op(w, ia, ib, ii);
      ref_sub(w, ia, ib, ii, ed, eb, ez);
      checks++;
      if (r_diff !== ed || r_bo !== eb || r_z !== ez || r_bits !== ed ||
          r_nvalid !== w || r_lat !== w || r_ndone !== 1 || r_coinc !== 1) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_w%0d: a=%h b=%h bin=%0d got diff=%h bo=%0d z=%0d bits=%h nv=%0d lat=%0d nd=%0d required diff=%h bo=%0d z=%0d",
                   w, ia, ib, ii, r_diff, r_bo, r_z, r_bits, r_nvalid, r_lat, r_ndone, ed, eb, ez);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_cases();
    test_back_to_back();
    test_async_reset();
    test_random(8, 1000);
    test_random(3, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
